// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared types and constants for the UART receive control stage
package uart_rx_pkg;

    localparam int DATA_W     = 8;
    localparam int PRESCALE_W = 6;
    localparam int BIT_CNT_W  = 6;

    localparam logic [PRESCALE_W-1:0] PS_8  = PRESCALE_W'(8);
    localparam logic [PRESCALE_W-1:0] PS_16 = PRESCALE_W'(16);
    localparam logic [PRESCALE_W-1:0] PS_32 = PRESCALE_W'(32);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Anything other than 16 or 32 is treated as the slowest-safe ratio of 8.
    function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] ps);
        return (ps == PS_16 || ps == PS_32) ? ps : PS_8;
    endfunction

endpackage

// File: rtl/uart_rx_fsm_if.sv
// rtl/uart_rx_fsm_if.sv - UART rx control bus; optional UART_RX_ERR_STATUS_EN adds err_clr/err_status
interface uart_rx_fsm_if;
    import uart_rx_pkg::*;

    logic                  RX_IN;
    logic [PRESCALE_W-1:0] prescale;
    logic                  PAR_EN;
    logic                  strt_glitch;
    logic                  par_err;
    logic                  stp_err;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  dat_samp_en;
    logic                  deser_en;
    logic                  strt_chk_en;
    logic                  par_chk_en;
    logic                  stp_chk_en;
    logic                  data_valid;
`ifdef UART_RX_ERR_STATUS_EN
    logic                  err_clr;
    logic [2:0]            err_status;
`endif

    modport master (
        input  RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
        output edge_cnt, bit_cnt, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en, data_valid
`ifdef UART_RX_ERR_STATUS_EN
        , input err_clr, output err_status
`endif
    );

    modport slave (
        output RX_IN, prescale, PAR_EN, strt_glitch, par_err, stp_err,
        input  edge_cnt, bit_cnt, dat_samp_en, deser_en,
               strt_chk_en, par_chk_en, stp_chk_en, data_valid
`ifdef UART_RX_ERR_STATUS_EN
        , output err_clr, input err_status
`endif
    );

endinterface

// File: rtl/uart_rx_edge_bit_cnt.sv
// rtl/uart_rx_edge_bit_cnt.sv - oversampling edge counter and frame bit counter
module uart_rx_edge_bit_cnt
    import uart_rx_pkg::*;
(
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    input  logic                  clear,
    input  logic [PRESCALE_W-1:0] ps_q,
    output logic [PRESCALE_W-1:0] edge_cnt,
    output logic [BIT_CNT_W-1:0]  bit_cnt,
    output logic                  last_edge
);

    assign last_edge = enable && (edge_cnt == ps_q - PRESCALE_W'(1));

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (clear) begin
            edge_cnt <= '0;
            bit_cnt  <= '0;
        end else if (enable) begin
            if (last_edge) begin
                edge_cnt <= '0;
                bit_cnt  <= bit_cnt + BIT_CNT_W'(1);
            end else begin
                edge_cnt <= edge_cnt + PRESCALE_W'(1);
            end
        end
    end

endmodule

// File: rtl/uart_rx_fsm.sv
// rtl/uart_rx_fsm.sv - UART rx frame sequencer; UART_RX_ERR_STATUS_EN adds sticky err_status
module uart_rx_fsm
    import uart_rx_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    uart_rx_fsm_if.master bus
);

    state_t                state;
    logic [PRESCALE_W-1:0] ps_q;
    logic                  par_q;
    logic                  frame_err;
    logic [PRESCALE_W-1:0] edge_cnt;
    logic [BIT_CNT_W-1:0]  bit_cnt;
    logic                  last_edge;
    logic                  pre_last;
    logic                  cnt_en;
    logic                  cnt_clear;

    assign cnt_en    = (state != IDLE);
    assign cnt_clear = last_edge && ((state == START && bus.strt_glitch) || state == STOP);
    // Strobes are registered, so they are armed one edge before the last edge.
    assign pre_last  = (edge_cnt == ps_q - PRESCALE_W'(2));

    uart_rx_edge_bit_cnt u_cnt (
        .CLK       (CLK),
        .RST       (RST),
        .enable    (cnt_en),
        .clear     (cnt_clear),
        .ps_q      (ps_q),
        .edge_cnt  (edge_cnt),
        .bit_cnt   (bit_cnt),
        .last_edge (last_edge)
    );

    assign bus.edge_cnt = edge_cnt;
    assign bus.bit_cnt  = bit_cnt;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state           <= IDLE;
            ps_q            <= PS_8;
            par_q           <= 1'b0;
            frame_err       <= 1'b0;
            bus.dat_samp_en <= 1'b0;
            bus.deser_en    <= 1'b0;
            bus.strt_chk_en <= 1'b0;
            bus.par_chk_en  <= 1'b0;
            bus.stp_chk_en  <= 1'b0;
            bus.data_valid  <= 1'b0;
        end else begin
            bus.deser_en    <= 1'b0;
            bus.strt_chk_en <= 1'b0;
            bus.par_chk_en  <= 1'b0;
            bus.stp_chk_en  <= 1'b0;
            bus.data_valid  <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.RX_IN) begin
                        state           <= START;
                        ps_q            <= legal_prescale(bus.prescale);
                        par_q           <= bus.PAR_EN;
                        frame_err       <= 1'b0;
                        bus.dat_samp_en <= 1'b1;
                    end
                end
                START: begin
                    bus.strt_chk_en <= pre_last;
                    if (last_edge) begin
                        if (bus.strt_glitch) begin
                            state           <= IDLE;
                            bus.dat_samp_en <= 1'b0;
                        end else begin
                            state <= DATA;
                        end
                    end
                end
                DATA: begin
                    bus.deser_en <= pre_last;
                    if (last_edge && bit_cnt == BIT_CNT_W'(DATA_W))
                        state <= par_q ? PARITY : STOP;
                end
                PARITY: begin
                    bus.par_chk_en <= pre_last;
                    if (last_edge) begin
                        frame_err <= frame_err | bus.par_err;
                        state     <= STOP;
                    end
                end
                STOP: begin
                    bus.stp_chk_en <= pre_last;
                    if (last_edge) begin
                        state           <= IDLE;
                        bus.dat_samp_en <= 1'b0;
                        bus.data_valid  <= !bus.stp_err && !frame_err;
                    end
                end
                default: begin
                    state           <= IDLE;
                    bus.dat_samp_en <= 1'b0;
                end
            endcase
        end
    end

`ifdef UART_RX_ERR_STATUS_EN
    logic [2:0] err_set;

    assign err_set = {last_edge && state == STOP   && bus.stp_err,
                      last_edge && state == PARITY && bus.par_err,
                      last_edge && state == START  && bus.strt_glitch};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            bus.err_status <= 3'b000;
        else
            bus.err_status <= (bus.err_clr ? 3'b000 : bus.err_status) | err_set;
    end
`endif

endmodule

// File: doc/uart_rx_fsm.md
Name: uart_rx_fsm

Overview:
- Control stage of the UART receive path. Sits directly upstream of the deserializer.
- Tracks oversampling edges and frame bit position, and sequences start/data/parity/stop handling.
- Drives deser_en and bit_cnt so the deserializer writes P_DATA[bit_cnt-1].
- Issues a one-cycle data_valid for each error-free frame.

Parameters:
- DATA_W, 8, data bits per frame; the data phase uses bit_cnt 1..DATA_W.
- PRESCALE_W, 6, width of the prescale input and of edge_cnt.
- BIT_CNT_W, 6, width of bit_cnt; matches the deserializer input.

Ports:
- CLK  in  1  oversampling clock.
- RST  in  1  asynchronous, active-high reset.
- RX_IN  in  1  serial line; idle high.
- prescale  in  PRESCALE_W  oversampling ratio. Legal values: 8, 16, 32.
- PAR_EN  in  1  frame carries a parity bit.
- strt_glitch  in  1  start-check result; valid in the strt_chk_en cycle.
- par_err  in  1  parity-check result; valid in the par_chk_en cycle.
- stp_err  in  1  stop-check result; valid in the stp_chk_en cycle.
- edge_cnt  out  PRESCALE_W  edge index within the current bit, 0..prescale-1.
- bit_cnt  out  BIT_CNT_W  frame bit index: 0 start, 1..DATA_W data, DATA_W+1 parity or stop.
- dat_samp_en  out  1  enables the data sampler.
- deser_en  out  1  one-cycle write strobe to the deserializer.
- strt_chk_en, par_chk_en, stp_chk_en  out  1 each  one-cycle check strobes.
- data_valid  out  1  one-cycle pulse: frame accepted.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0, including edge_cnt and bit_cnt.
  - Reset asserted mid-frame aborts the frame: no data_valid and no strobes.
- States: IDLE, START, DATA, PARITY, STOP.
- Latching at frame start: on the IDLE->START transition, prescale and PAR_EN are latched (ps_q, par_q).
  - Changes to prescale or PAR_EN mid-frame are ignored.
  - An illegal prescale value is latched as 8.
- Counters (outside IDLE):
  - edge_cnt increments every cycle. At ps_q-1 it wraps to 0 and bit_cnt increments.
  - Let "last edge" mean edge_cnt==ps_q-1.
- dat_samp_en is 1 in every state except IDLE.
- IDLE:
  - Stays while RX_IN=1.
  - RX_IN=0 -> START, with edge_cnt=0 and bit_cnt=0.
- START:
  - At last edge, strt_chk_en pulses.
  - If strt_glitch=1 in that cycle -> IDLE, counters cleared.
  - Otherwise -> DATA with bit_cnt=1.
- DATA:
  - At last edge, deser_en pulses; bit_cnt holds the current data index, 1..DATA_W.
  - After bit_cnt=DATA_W -> PARITY if par_q, else STOP.
- PARITY:
  - bit_cnt=DATA_W+1. At last edge, par_chk_en pulses.
  - par_err is captured into a frame-error flag; the state always moves to STOP.
- STOP:
  - bit_cnt=DATA_W+1 without parity, DATA_W+2 with parity.
  - At last edge, stp_chk_en pulses, then -> IDLE with counters cleared.
  - data_valid pulses in the next cycle only if stp_err=0 and the frame-error flag is 0.
- Back-to-back frames: if RX_IN=0 in the cycle data_valid is high, IDLE moves to START in that same cycle. No idle gap is required.
- Mutual exclusion: all strobes are registered and at most one is high per cycle.
  - data_valid never coincides with deser_en.

Optional Feature:
- Macro: UART_RX_ERR_STATUS_EN.
- When defined:
  - Adds output err_status[2:0] = {stop, parity, start-glitch}.
  - Bits are sticky, set by the corresponding error.
  - Cleared by RST or by a new input err_clr (1 bit, synchronous, one cycle).
  - If err_clr and a new error occur in the same cycle, the set wins.
- When undefined: neither port exists and frame behaviour is identical.

Decomposition:
- Shared package (uart_rx_pkg) holds:
  - the state enum with encodings IDLE=0, START=1, DATA=2, PARITY=3, STOP=4;
  - the constants DATA_W, PRESCALE_W and BIT_CNT_W;
  - the legal prescale values.
- One sub-module: uart_rx_edge_bit_cnt, holding the edge_cnt/bit_cnt counters.
  - Inputs: enable, ps_q, clear.
  - Output: last-edge flag.
- The FSM stays in uart_rx_fsm.

Test Plan:
1. Prescale=8, PAR_EN=0, frame 0xA5 LSB first, stop=1:
   - eight deser_en pulses at bit_cnt 1..8, each at edge_cnt 7;
   - stp_chk_en at bit_cnt 9;
   - data_valid 1 cycle later;
   - total 80 cycles from start edge to stop last edge.
2. Prescale=16, PAR_EN=1, even parity, par_err=1 forced in the par_chk_en cycle:
   - par_chk_en at bit_cnt 9, stp_chk_en at bit_cnt 10;
   - no data_valid; FSM back in IDLE.
3. Start glitch:
   - RX_IN low for 3 cycles, strt_glitch=1 at the START last edge;
   - -> IDLE with no deser_en and bit_cnt=0;
   - then a valid frame 0x3C is received normally.
4. Back-to-back, prescale=32: two frames 0x01 and 0xFF with RX_IN low in the data_valid cycle:
   - second START entered in the same cycle, both data_valid pulses seen;
   - prescale changed to 8 mid-frame has no effect.
5. RST asserted at bit_cnt 4 of DATA:
   - all outputs 0 asynchronously, no data_valid;
   - after release, the next frame is received correctly.
6. With UART_RX_ERR_STATUS_EN defined:
   - stp_err=1 sets err_status=3'b100, which persists across a good frame;
   - err_clr clears it to 000;
   - err_clr coincident with a new stop error leaves it at 100.
